// File: rtl/fetch_queue_d_if.sv
// Fetch-to-decode handshake bundle for fetch_queue_d.
// The master side drives fetched triples and the decode stall; the slave side is the queue.
interface fetch_queue_d_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  ValidF;
  logic [DATA_WIDTH-1:0] RD;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] PCPlus4F;
  logic                  ReadyF;
  logic                  StallD;
  logic                  ValidD;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic [CNT_WIDTH-1:0]  Count;

  modport master (
    output ValidF, RD, PCF, PCPlus4F, StallD,
    input  ReadyF, ValidD, InstrD, PCD, PCPlus4D, Count
  );

  modport slave (
    input  ValidF, RD, PCF, PCPlus4F, StallD,
    output ReadyF, ValidD, InstrD, PCD, PCPlus4D, Count
  );
endinterface

// File: rtl/fetch_queue_d.sv
// DEPTH-entry circular instruction queue between instruction fetch and decode.
// Holds {instruction, PC, PC+4} triples and presents the oldest one to decode.
module fetch_queue_d #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CLR,
  fetch_queue_d_if.slave  bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] instrMem   [DEPTH];
  logic [DATA_WIDTH-1:0] pcMem      [DEPTH];
  logic [DATA_WIDTH-1:0] pcPlus4Mem [DEPTH];

  logic [PTR_WIDTH-1:0] rdPtr;
  logic [PTR_WIDTH-1:0] wrPtr;
  logic [CNT_WIDTH-1:0] count;

  logic full;
  logic empty;
  logic doPush;
  logic doPop;

  assign full   = (count == CNT_WIDTH'(DEPTH));
  assign empty  = (count == '0);
  // Push is gated by the pre-edge full flag, so a slot freed by a pop is only usable next cycle.
  assign doPush = bus.ValidF && !full;
  assign doPop  = !empty && !bus.StallD;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_WIDTH'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_WIDTH'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; stale entries are never visible because outputs are masked when empty.
  always_ff @(posedge CLK) begin
    if (!RST && !CLR && doPush) begin
      instrMem[wrPtr]   <= bus.RD;
      pcMem[wrPtr]      <= bus.PCF;
      pcPlus4Mem[wrPtr] <= bus.PCPlus4F;
    end
  end

  assign bus.ReadyF   = !full;
  assign bus.ValidD   = !empty;
  assign bus.InstrD   = empty ? '0 : instrMem[rdPtr];
  assign bus.PCD      = empty ? '0 : pcMem[rdPtr];
  assign bus.PCPlus4D = empty ? '0 : pcPlus4Mem[rdPtr];
  assign bus.Count    = count;
endmodule

// File: tb/tb_fetch_queue_d.sv
// Directed self-checking bench for fetch_queue_d (DATA_WIDTH=32, DEPTH=4).
module tb_fetch_queue_d;
  logic CLK;
  logic RST;
  logic CLR;

  int checks   = 0;
  int failures = 0;

  fetch_queue_d_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();

  fetch_queue_d #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return 32'hA000_0000 ^ (pc << 4) ^ 32'h13;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic stall);
    bus.ValidF   = v;
    bus.PCF      = pc;
    bus.RD       = instrOf(pc);
    bus.PCPlus4F = pc + 32'd4;
    bus.StallD   = stall;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 32'(bus.ValidD), 32'd1);
    checkOutput({tag, "_pcd"}, bus.PCD, pc);
    checkOutput({tag, "_instr"}, bus.InstrD, instrOf(pc));
    checkOutput({tag, "_pc4"}, bus.PCPlus4D, pc + 32'd4);
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.ValidD), 32'd0);
    checkOutput({tag, "_count"}, 32'(bus.Count), 32'd0);
    checkOutput({tag, "_instr"}, bus.InstrD, 32'd0);
    checkOutput({tag, "_pcd"}, bus.PCD, 32'd0);
    checkOutput({tag, "_pc4"}, bus.PCPlus4D, 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.ReadyF), 32'd1);
  endtask

  logic [31:0] model[$];
  logic [31:0] wrapPc;
  logic        mPush;
  logic        mPop;
  logic [9:0]  wrapValid;
  logic [9:0]  wrapStall;

  initial begin
    RST = 1'b1;
    CLR = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0);
    tick();
    RST = 1'b0;
    checkBubble("reset");

    // Fill with decode stalled; head must stay on the first triple.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 1'b1);
      tick();
      checkOutput($sformatf("fill_count%0d", i), 32'(bus.Count), 32'(i + 1));
      checkHead($sformatf("fill_head%0d", i), 32'h0);
    end
    checkOutput("fill_ready", 32'(bus.ReadyF), 32'd0);

    // Push attempts while full are dropped.
    applyStimulus(1'b1, 32'h100, 1'b1);
    tick();
    tick();
    checkOutput("full_count", 32'(bus.Count), 32'd4);
    checkHead("full_head", 32'h0);
    checkOutput("full_ready", 32'(bus.ReadyF), 32'd0);

    // Pop while full: no push in the same cycle.
    applyStimulus(1'b1, 32'h100, 1'b0);
    tick();
    checkOutput("fullpop_count", 32'(bus.Count), 32'd3);
    checkHead("fullpop_head", 32'h4);
    checkOutput("fullpop_ready", 32'(bus.ReadyF), 32'd1);
    applyStimulus(1'b1, 32'h100, 1'b1);
    tick();
    checkOutput("refill_count", 32'(bus.Count), 32'd4);
    checkHead("refill_head", 32'h4);

    // Drain in order.
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkHead("drain0", 32'h8);
    tick();
    checkHead("drain1", 32'hC);
    tick();
    checkHead("drain2", 32'h100);
    checkOutput("drain2_count", 32'(bus.Count), 32'd1);
    tick();
    checkBubble("drained");

    // Streaming: head lags fetch by one cycle, occupancy stays 1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), 1'b0);
      tick();
      checkOutput($sformatf("stream_count%0d", i), 32'(bus.Count), 32'd1);
      checkHead($sformatf("stream%0d", i), 32'h40 + 32'(4 * i));
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkBubble("stream_end");

    // Flush beats push and pop.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h80 + 32'(4 * i), 1'b1);
      tick();
    end
    checkOutput("preflush_count", 32'(bus.Count), 32'd3);
    CLR = 1'b1;
    applyStimulus(1'b1, 32'h300, 1'b0);
    tick();
    CLR = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkBubble("flush");
    applyStimulus(1'b1, 32'h200, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkHead("postflush", 32'h200);
    checkOutput("postflush_count", 32'(bus.Count), 32'd1);
    tick();
    checkBubble("postflush_pop");

    // Wrap-around against a reference queue.
    wrapValid = 10'b10_1011_1111;
    wrapStall = 10'b10_0011_1011;
    wrapPc    = 32'h400;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(wrapValid[i], wrapPc, wrapStall[i]);
      mPush = wrapValid[i] && (model.size() < 4);
      mPop  = (model.size() > 0) && !wrapStall[i];
      tick();
      if (mPop) void'(model.pop_front());
      if (mPush) begin
        model.push_back(wrapPc);
        wrapPc = wrapPc + 32'd4;
      end
      checkOutput($sformatf("wrap_count%0d", i), 32'(bus.Count), 32'(model.size()));
      if (model.size() > 0) checkHead($sformatf("wrap%0d", i), model[0]);
      else checkOutput($sformatf("wrap_valid%0d", i), 32'(bus.ValidD), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    while (model.size() > 0) begin
      tick();
      void'(model.pop_front());
      checkOutput("wrapdrain_count", 32'(bus.Count), 32'(model.size()));
      if (model.size() > 0) checkHead("wrapdrain", model[0]);
    end
    checkBubble("wrap_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
